// File: rtl/bfp_conv_arbiter_pkg.sv
// Shared fixed-point widths, FSM encoding and channel-tag width helper
// for the block-floating-point converter arbiter.
package bfp_conv_arbiter_pkg;

  localparam int MAN_WIDTH     = 12;
  localparam int EXP_WIDTH     = 5;
  localparam int FFT_OUT_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  // Channel tag width; a 2-channel arbiter still needs one tag bit.
  function automatic int ch_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/bfp_conv_arbiter_rr_arb.sv
// NCH-way round-robin picker: scans from the channel after last_grant_i
// and returns the first requesting channel. Purely combinational.
module bfp_rr_arb
  import bfp_conv_arbiter_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int CH_W = ch_width(NCH)
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [CH_W-1:0] last_grant_i,
  output logic [CH_W-1:0] grant_o,
  output logic            hit_o
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int idx;
    grant_o = '0;
    hit_o   = 1'b0;
    idx     = 0;
    for (int i = NCH; i >= 1; i--) begin
      idx = (int'(last_grant_i) + i) % NCH;
      if (req_i[idx]) begin
        grant_o = CH_W'(idx);
        hit_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bfp_conv_arbiter.sv
// Block-granular round-robin arbiter sharing one BFP-to-fixed converter
// between NCH DFT output channels. A channel tag travels alongside the
// converter latency so every fixed-point result leaves tagged.
module bfp_conv_arbiter
  import bfp_conv_arbiter_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int CH_W      = ch_width(NCH),
  parameter int BLK_LEN_W = 11,
  parameter int CONV_LAT  = 1
) (
  input  logic                         clk_sys,
  input  logic                         rst_sys_n,
  input  logic [BLK_LEN_W-1:0]         blk_len_i,
  input  logic [NCH-1:0]               req_valid_i,
  input  logic [NCH-1:0]               req_sop_i,
  input  logic [NCH*MAN_WIDTH-1:0]     req_real_i,
  input  logic [NCH*MAN_WIDTH-1:0]     req_imag_i,
  input  logic [NCH*EXP_WIDTH-1:0]     req_exp_i,
  output logic [NCH-1:0]               req_ready_o,
  output logic                         cv_block_sync_o,
  output logic                         cv_data_val_o,
  output logic [MAN_WIDTH-1:0]         cv_real_o,
  output logic [MAN_WIDTH-1:0]         cv_imag_o,
  output logic [EXP_WIDTH-1:0]         cv_exp_o,
  input  logic                         cv_block_sync_i,
  input  logic                         cv_data_val_i,
  input  logic [FFT_OUT_WIDTH-1:0]     cv_real_i,
  input  logic [FFT_OUT_WIDTH-1:0]     cv_imag_i,
  output logic                         out_val_o,
  output logic                         out_sop_o,
  output logic [CH_W-1:0]              out_ch_o,
  output logic [FFT_OUT_WIDTH-1:0]     out_real_o,
  output logic [FFT_OUT_WIDTH-1:0]     out_imag_o,
  output logic                         busy_o,
  output logic                         err_sop_o
);

  state_e                 state_q, state_d;
  logic [CH_W-1:0]        grant_q, grant_d;
  logic [CH_W-1:0]        last_grant_q, last_grant_d;
  logic [BLK_LEN_W-1:0]   len_q, len_d;
  logic [BLK_LEN_W-1:0]   cnt_q, cnt_d;

  logic [CH_W-1:0]        arb_grant;
  logic                   arb_hit;
  logic [NCH-1:0]         ready;
  logic                   beat;
  logic                   cv_val_d, cv_sync_d, err_d;

  logic                   cv_val_q, cv_sync_q, err_q;
  logic [MAN_WIDTH-1:0]   cv_real_q, cv_imag_q;
  logic [EXP_WIDTH-1:0]   cv_exp_q;
  logic [CH_W-1:0]        cv_ch_q;

  // Tag entry = {channel, valid}; last stage lines up with cv_data_val_i.
  logic [CH_W:0]          tag_q [CONV_LAT];
  logic [CH_W-1:0]        tag_ch;
  logic                   tag_val;

  logic                   out_val_q, out_sop_q;
  logic [CH_W-1:0]        out_ch_q;
  logic [FFT_OUT_WIDTH-1:0] out_real_q, out_imag_q;

  logic [MAN_WIDTH-1:0]   sel_real, sel_imag;
  logic [EXP_WIDTH-1:0]   sel_exp;

  bfp_rr_arb #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_rr_arb (
    .req_i        (req_valid_i & req_sop_i),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .hit_o        (arb_hit)
  );

  assign sel_real = req_real_i[int'(grant_q)*MAN_WIDTH +: MAN_WIDTH];
  assign sel_imag = req_imag_i[int'(grant_q)*MAN_WIDTH +: MAN_WIDTH];
  assign sel_exp  = req_exp_i[int'(grant_q)*EXP_WIDTH +: EXP_WIDTH];

  // Next-state and handshake: grant a block start in IDLE (or discard a
  // stray mid-block beat), stream the granted channel in XFER.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    ready        = '0;
    beat         = 1'b0;
    cv_val_d     = 1'b0;
    cv_sync_d    = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_hit) begin
          // Grant cycle accepts nothing: this is the inter-block bubble.
          state_d      = XFER;
          grant_d      = arb_grant;
          last_grant_d = arb_grant;
          len_d        = (blk_len_i == '0) ? BLK_LEN_W'(1) : blk_len_i;
          cnt_d        = '0;
        end else begin
          ready = req_valid_i & ~req_sop_i;
          err_d = |ready;
        end
      end
      XFER: begin
        ready[grant_q] = 1'b1;
        beat           = req_valid_i[grant_q];
        if (beat) begin
          cv_val_d  = 1'b1;
          cv_sync_d = (cnt_q == '0);
          err_d     = req_sop_i[grant_q] && (cnt_q != '0);
          if (cnt_q == len_q - 1'b1) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and block bookkeeping registers.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_W'(NCH - 1);
      len_q        <= BLK_LEN_W'(1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
    end
  end

  // ---- stage p0: accepted beat registered onto the converter interface
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      cv_val_q  <= 1'b0;
      cv_sync_q <= 1'b0;
      err_q     <= 1'b0;
      cv_real_q <= '0;
      cv_imag_q <= '0;
      cv_exp_q  <= '0;
      cv_ch_q   <= '0;
    end else begin
      cv_val_q  <= cv_val_d;
      cv_sync_q <= cv_sync_d;
      err_q     <= err_d;
      if (beat) begin
        cv_real_q <= sel_real;
        cv_imag_q <= sel_imag;
        cv_exp_q  <= sel_exp;
        cv_ch_q   <= grant_q;
      end
    end
  end

  // ---- tag stages: channel tag shadows the converter latency
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      for (int k = 0; k < CONV_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= {cv_ch_q, cv_val_q};
      for (int k = 1; k < CONV_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign tag_ch  = tag_q[CONV_LAT-1][CH_W:1];
  assign tag_val = tag_q[CONV_LAT-1][0];

  // ---- output stage: tagged result register; data and tag hold between samples
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      out_val_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_ch_q   <= '0;
      out_real_q <= '0;
      out_imag_q <= '0;
    end else begin
      out_val_q <= cv_data_val_i;
      out_sop_q <= cv_block_sync_i;
      if (tag_val) out_ch_q <= tag_ch;
      if (cv_data_val_i) begin
        out_real_q <= cv_real_i;
        out_imag_q <= cv_imag_i;
      end
    end
  end

  assign req_ready_o     = ready;
  assign cv_block_sync_o = cv_sync_q;
  assign cv_data_val_o   = cv_val_q;
  assign cv_real_o       = cv_real_q;
  assign cv_imag_o       = cv_imag_q;
  assign cv_exp_o        = cv_exp_q;
  assign out_val_o       = out_val_q;
  assign out_sop_o       = out_sop_q;
  assign out_ch_o        = out_ch_q;
  assign out_real_o      = out_real_q;
  assign out_imag_o      = out_imag_q;
  assign busy_o          = (state_q == XFER);
  assign err_sop_o       = err_q;

endmodule

// File: tb/tb_bfp_conv_arbiter.sv
// Directed bench: a 2-channel/latency-1 instance and a 4-channel/latency-3
// instance, each fed by a simple converter model (real = sign-extended
// mantissa, imag = sign-extended mantissa + sign-extended exponent).
module tb_bfp_conv_arbiter;
  import bfp_conv_arbiter_pkg::*;

  typedef struct {
    int          cyc;
    int          ch;
    logic        sop;
    logic [15:0] re;
    logic [15:0] im;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [10:0] blk_len;
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 2-channel instance
  logic [1:0]  v2, s2, rdy2;
  logic [23:0] re2, im2;
  logic [9:0]  ex2;
  logic        cvs2, cvv2, cvsi2, cvvi2, ov2, os2, busy2, err2;
  logic [11:0] cvre2, cvim2;
  logic [4:0]  cvex2;
  logic [15:0] cvrei2, cvimi2, ore2, oim2;
  logic [0:0]  oc2;

  bfp_conv_arbiter dut2 (
    .clk_sys(clk), .rst_sys_n(rst_n), .blk_len_i(blk_len),
    .req_valid_i(v2), .req_sop_i(s2), .req_real_i(re2), .req_imag_i(im2), .req_exp_i(ex2),
    .req_ready_o(rdy2), .cv_block_sync_o(cvs2), .cv_data_val_o(cvv2),
    .cv_real_o(cvre2), .cv_imag_o(cvim2), .cv_exp_o(cvex2),
    .cv_block_sync_i(cvsi2), .cv_data_val_i(cvvi2), .cv_real_i(cvrei2), .cv_imag_i(cvimi2),
    .out_val_o(ov2), .out_sop_o(os2), .out_ch_o(oc2), .out_real_o(ore2), .out_imag_o(oim2),
    .busy_o(busy2), .err_sop_o(err2)
  );

  // ---------------- 4-channel instance, converter latency 3
  logic [3:0]  v4, s4, rdy4;
  logic [47:0] re4, im4;
  logic [19:0] ex4;
  logic        cvs4, cvv4, cvsi4, cvvi4, ov4, os4, busy4, err4;
  logic [11:0] cvre4, cvim4;
  logic [4:0]  cvex4;
  logic [15:0] cvrei4, cvimi4, ore4, oim4;
  logic [1:0]  oc4;

  bfp_conv_arbiter #(.NCH(4), .CONV_LAT(3)) dut4 (
    .clk_sys(clk), .rst_sys_n(rst_n), .blk_len_i(blk_len),
    .req_valid_i(v4), .req_sop_i(s4), .req_real_i(re4), .req_imag_i(im4), .req_exp_i(ex4),
    .req_ready_o(rdy4), .cv_block_sync_o(cvs4), .cv_data_val_o(cvv4),
    .cv_real_o(cvre4), .cv_imag_o(cvim4), .cv_exp_o(cvex4),
    .cv_block_sync_i(cvsi4), .cv_data_val_i(cvvi4), .cv_real_i(cvrei4), .cv_imag_i(cvimi4),
    .out_val_o(ov4), .out_sop_o(os4), .out_ch_o(oc4), .out_real_o(ore4), .out_imag_o(oim4),
    .busy_o(busy4), .err_sop_o(err4)
  );

  function automatic logic [15:0] sx12(input logic [11:0] x);
    return {{4{x[11]}}, x};
  endfunction
  function automatic logic [15:0] sx5(input logic [4:0] x);
    return {{11{x[4]}}, x};
  endfunction

  // Converter models
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cvvi2 <= 1'b0; cvsi2 <= 1'b0; cvrei2 <= '0; cvimi2 <= '0;
    end else begin
      cvvi2 <= cvv2; cvsi2 <= cvs2;
      cvrei2 <= sx12(cvre2); cvimi2 <= sx12(cvim2) + sx5(cvex2);
    end
  end

  logic        pv4 [3];
  logic        ps4 [3];
  logic [15:0] pr4 [3];
  logic [15:0] pi4 [3];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        pv4[k] <= 1'b0; ps4[k] <= 1'b0; pr4[k] <= '0; pi4[k] <= '0;
      end
    end else begin
      pv4[0] <= cvv4; ps4[0] <= cvs4;
      pr4[0] <= sx12(cvre4); pi4[0] <= sx12(cvim4) + sx5(cvex4);
      for (int k = 1; k < 3; k++) begin
        pv4[k] <= pv4[k-1]; ps4[k] <= ps4[k-1]; pr4[k] <= pr4[k-1]; pi4[k] <= pi4[k-1];
      end
    end
  end
  assign cvvi4 = pv4[2];
  assign cvsi4 = ps4[2];
  assign cvrei4 = pr4[2];
  assign cvimi4 = pi4[2];

  // Event recorders (observation only; expectations are constants below)
  ev_t out2[$], acc2[$], out4[$], acc4[$];
  int nerr2 = 0, ncvv2 = 0, ncvs2 = 0, r1hi2 = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < 2; c++)
        if (v2[c] && rdy2[c])
          acc2.push_back('{cyc: cyc, ch: c, sop: s2[c], re: {4'h0, re2[c*12 +: 12]}, im: '0});
      for (int c = 0; c < 4; c++)
        if (v4[c] && rdy4[c])
          acc4.push_back('{cyc: cyc, ch: c, sop: s4[c], re: {4'h0, re4[c*12 +: 12]}, im: '0});
      if (ov2) out2.push_back('{cyc: cyc, ch: int'(oc2), sop: os2, re: ore2, im: oim2});
      if (ov4) out4.push_back('{cyc: cyc, ch: int'(oc4), sop: os4, re: ore4, im: oim4});
      if (err2) nerr2 = nerr2 + 1;
      if (cvv2) ncvv2 = ncvv2 + 1;
      if (cvs2) ncvs2 = ncvs2 + 1;
      if (rdy2[1]) r1hi2 = r1hi2 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Imag mantissa is always -1 and exponent 2, so the model's imag result is 1.
  task automatic drive(input bit d4, input int ch, input logic v, input logic s, input logic [11:0] r);
    if (d4) begin
      v4[ch] = v; s4[ch] = s;
      re4[ch*12 +: 12] = r; im4[ch*12 +: 12] = 12'hFFF; ex4[ch*5 +: 5] = 5'd2;
    end else begin
      v2[ch] = v; s2[ch] = s;
      re2[ch*12 +: 12] = r; im2[ch*12 +: 12] = 12'hFFF; ex2[ch*5 +: 5] = 5'd2;
    end
  endtask

  function automatic logic rdy(input bit d4, input int ch);
    return d4 ? rdy4[ch] : rdy2[ch];
  endfunction

  // Send n beats with real = base+k; sopmask/gapmask bit k marks sop on beat k
  // and an idle cycle before beat k.
  task automatic stream(input bit d4, input int ch, input int n, input int base,
                        input int sopmask, input int gapmask);
    int w;
    for (int k = 0; k < n; k++) begin
      if (gapmask[k]) tick();
      drive(d4, ch, 1'b1, sopmask[k], 12'(base + k));
      w = 0;
      @(negedge clk);
      while (!rdy(d4, ch) && w < 60) begin
        w++;
        @(negedge clk);
      end
      n_assert++;
      assert (w < 60) else begin
        n_fail++;
        $error("FAIL accept_ch%0d: waited %0d cycles, required < 60", ch, w);
      end
      tick();
      drive(d4, ch, 1'b0, 1'b0, 12'h0);
      if (w >= 60) return;
    end
  endtask

  task automatic do_reset();
    v2 = '0; s2 = '0; v4 = '0; s4 = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bo, ba, be, bv, bs, br;
    int e_ch2[9];
    int e_re2[9];
    int e_ch3[8];
    int e_re3[8];
    int e_ch6[5];
    int e_re6[5];
    e_ch2 = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    e_re2 = '{'h20, 'h21, 'h22, 'h30, 'h31, 'h32, 'h40, 'h41, 'h42};
    e_ch3 = '{0, 0, 0, 0, 1, 1, 1, 1};
    e_re3 = '{'h50, 'h51, 'h52, 'h53, 'h60, 'h61, 'h62, 'h63};
    e_ch6 = '{0, 1, 2, 3, 0};
    e_re6 = '{'hB0, 'hB1, 'hB2, 'hB3, 'hB4};

    rst_n = 1'b0; blk_len = 11'd4;
    v2 = '0; s2 = '0; re2 = '0; im2 = '0; ex2 = '0;
    v4 = '0; s4 = '0; re4 = '0; im4 = '0; ex4 = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_out_val2", ov2, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_cv_val2", cvv2, 0);
    chk("rst_ready2", rdy2, 0);
    chk("rst_out_real2", ore2, 0);
    chk("rst_err2", err2, 0);
    chk("rst_out_val4", ov4, 0);
    chk("rst_busy4", busy4, 0);
    #2 rst_n = 1'b1;
    tick();

    // T1: single-channel block of 4
    bo = out2.size(); ba = acc2.size(); be = nerr2; bv = ncvv2; bs = ncvs2;
    stream(0, 0, 4, 'h10, 1, 0);
    repeat (6) tick();
    chk("t1_nout", out2.size() - bo, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_ch%0d", i), out2[bo+i].ch, 0);
      chk($sformatf("t1_sop%0d", i), out2[bo+i].sop, (i == 0) ? 1 : 0);
      chk($sformatf("t1_re%0d", i), out2[bo+i].re, 'h10 + i);
    end
    chk("t1_imag", out2[bo].im, 16'h0001);
    chk("t1_latency", out2[bo].cyc - acc2[ba].cyc, 3);
    chk("t1_cv_sync_cnt", ncvs2 - bs, 1);
    chk("t1_cv_val_cnt", ncvv2 - bv, 4);
    chk("t1_err_cnt", nerr2 - be, 0);
    chk("t1_hold_real", ore2, 16'h0013);
    chk("t1_busy_end", busy2, 0);

    // T2: ch0 and ch1 contend from reset, blk_len 3
    do_reset();
    blk_len = 11'd3;
    bo = out2.size();
    fork
      begin
        stream(0, 0, 3, 'h20, 1, 0);
        stream(0, 0, 3, 'h40, 1, 0);
      end
      stream(0, 1, 3, 'h30, 1, 0);
    join
    repeat (6) tick();
    chk("t2_nout", out2.size() - bo, 9);
    if (out2.size() - bo >= 9) begin
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("t2_ch%0d", i), out2[bo+i].ch, e_ch2[i]);
        chk($sformatf("t2_re%0d", i), out2[bo+i].re, e_re2[i]);
      end
      chk("t2_bubble_a", out2[bo+3].cyc - out2[bo+2].cyc, 2);
      chk("t2_bubble_b", out2[bo+6].cyc - out2[bo+5].cyc, 2);
    end

    // T3: ch1 waits while ch0 streams with gaps
    do_reset();
    blk_len = 11'd4;
    bo = out2.size(); ba = acc2.size(); br = r1hi2; bv = ncvv2; bs = ncvs2;
    fork
      begin
        stream(0, 0, 4, 'h50, 1, 'b1010);
        chk("t3_ready1_low", r1hi2 - br, 0);
      end
      stream(0, 1, 4, 'h60, 1, 0);
    join
    repeat (6) tick();
    chk("t3_nout", out2.size() - bo, 8);
    if (out2.size() - bo >= 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("t3_ch%0d", i), out2[bo+i].ch, e_ch3[i]);
        chk($sformatf("t3_re%0d", i), out2[bo+i].re, e_re3[i]);
        chk($sformatf("t3_sop%0d", i), out2[bo+i].sop, (i == 0 || i == 4) ? 1 : 0);
      end
      chk("t3_gap_spacing", out2[bo+1].cyc - out2[bo].cyc, 2);
      chk("t3_ch1_first_acc", acc2[ba+4].ch, 1);
      chk("t3_grant_after_b4", acc2[ba+4].cyc - acc2[ba+3].cyc, 2);
    end
    chk("t3_cv_val_cnt", ncvv2 - bv, 8);
    chk("t3_cv_sync_cnt", ncvs2 - bs, 2);

    // T4: framing errors
    do_reset();
    blk_len = 11'd4;
    bo = out2.size(); ba = acc2.size(); be = nerr2; bv = ncvv2;
    stream(0, 0, 1, 'h70, 0, 0);
    repeat (4) tick();
    chk("t4_idle_consumed", acc2.size() - ba, 1);
    chk("t4_idle_err", nerr2 - be, 1);
    chk("t4_idle_no_cv", ncvv2 - bv, 0);
    chk("t4_idle_no_out", out2.size() - bo, 0);
    chk("t4_idle_busy", busy2, 0);
    be = nerr2; bv = ncvv2;
    stream(0, 0, 4, 'h80, 'b0101, 0);
    repeat (6) tick();
    chk("t4_mid_err", nerr2 - be, 1);
    chk("t4_mid_cv_val", ncvv2 - bv, 4);
    chk("t4_mid_nout", out2.size() - bo, 4);
    if (out2.size() - bo >= 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("t4_sop%0d", i), out2[bo+i].sop, (i == 0) ? 1 : 0);
    chk("t4_len_kept", busy2, 0);

    // T5: asynchronous reset mid-block
    do_reset();
    blk_len = 11'd8;
    bo = out2.size();
    begin
      int w;
      drive(0, 0, 1'b1, 1'b1, 12'h90);
      w = 0;
      @(negedge clk);
      while (!rdy2[0] && w < 20) begin
        w++;
        @(negedge clk);
      end
      chk("t5_grant_wait", (w < 20) ? 1 : 0, 1);
    end
    tick();
    drive(0, 0, 1'b1, 1'b0, 12'h91);
    tick();
    drive(0, 0, 1'b0, 1'b0, 12'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_cv_val", cvv2, 0);
    chk("t5_cv_real", cvre2, 0);
    chk("t5_busy", busy2, 0);
    chk("t5_ready", rdy2, 0);
    chk("t5_out_val", ov2, 0);
    chk("t5_err", err2, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) tick();
    chk("t5_no_stale", out2.size() - bo, 0);
    blk_len = 11'd1;
    fork
      stream(0, 1, 1, 'hA1, 1, 0);
      stream(0, 0, 1, 'hA0, 1, 0);
    join
    repeat (6) tick();
    chk("t5_nout", out2.size() - bo, 2);
    if (out2.size() - bo >= 2) begin
      chk("t5_first_ch", out2[bo].ch, 0);
      chk("t5_second_ch", out2[bo+1].ch, 1);
    end

    // T6: 4 channels, latency-3 converter, blk_len 1
    do_reset();
    blk_len = 11'd1;
    bo = out4.size(); ba = acc4.size();
    fork
      begin
        stream(1, 0, 1, 'hB0, 1, 0);
        stream(1, 0, 1, 'hB4, 1, 0);
      end
      stream(1, 1, 1, 'hB1, 1, 0);
      stream(1, 2, 1, 'hB2, 1, 0);
      stream(1, 3, 1, 'hB3, 1, 0);
    join
    repeat (10) tick();
    chk("t6_nout", out4.size() - bo, 5);
    if (out4.size() - bo >= 5 && acc4.size() - ba >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("t6_ch%0d", i), out4[bo+i].ch, e_ch6[i]);
        chk($sformatf("t6_re%0d", i), out4[bo+i].re, e_re6[i]);
        chk($sformatf("t6_lat%0d", i), out4[bo+i].cyc - acc4[ba+i].cyc, 5);
        if (i > 0) chk($sformatf("t6_bubble%0d", i), acc4[ba+i].cyc - acc4[ba+i-1].cyc, 2);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
